// File: rtl/cfg_port_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_port_arbiter
//
// Purpose:
//   Two-port arbiter in front of a single configuration register file.
//   Port r0 carries NoC configuration packets, port r1 carries local host
//   accesses. One request is in flight at a time. Requests are granted
//   round-robin, issued as a one-cycle write or read strobe, and reads return
//   their data on a response channel tagged with the source port.
//
// Build option:
//   CFG_WR_ACK_EN - when defined, every write also produces one response
//                   (rsp_rdata = 0, rsp_id = source port). When undefined,
//                   writes complete silently.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   r0_* / r1_*             request ports: valid, ready, wr, addr, wdata
//   rsp_valid, rsp_ready    response handshake
//   rsp_id, rsp_rdata       response source port and read data
//   config_we, config_re    one-cycle write / read strobes (never together)
//   config_waddr/raddr      target address (same latched value on both)
//   config_wdata            write data
//   config_rdata            read data, valid one cycle after config_re
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RSP)
//
// Handshake rule (all channels): a transfer happens on the rising clk edge
// where valid and ready are both high. A request holds valid and its payload
// stable until accepted; the response channel holds rsp_valid, rsp_id and
// rsp_rdata stable until rsp_ready is seen high.
// ---------------------------------------------------------------------------
module cfg_port_arbiter #(
  parameter int CAW = 15,
  parameter int CDW = 21
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic           r0_wr,
  input  logic [CAW-1:0] r0_addr,
  input  logic [CDW-1:0] r0_wdata,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic           r1_wr,
  input  logic [CAW-1:0] r1_addr,
  input  logic [CDW-1:0] r1_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [CDW-1:0] rsp_rdata,
  output logic           config_we,
  output logic           config_re,
  output logic [CAW-1:0] config_waddr,
  output logic [CAW-1:0] config_raddr,
  output logic [CDW-1:0] config_wdata,
  input  logic [CDW-1:0] config_rdata,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RSP     = 2'd3
  } state_t;

  state_t         state;
  logic           pref_id;    // port that wins when both ports are valid
  logic           lat_wr;
  logic [CAW-1:0] lat_addr;
  logic [CDW-1:0] lat_wdata;
  logic           lat_id;

  logic           gnt_id;
  logic           hs;
  logic           sel_wr;
  logic [CAW-1:0] sel_addr;
  logic [CDW-1:0] sel_wdata;

  // Round-robin grant: a lone valid port always wins; on contention the
  // preferred port (the one not granted last) wins.
  always_comb begin
    gnt_id = 1'b0;
    if (r0_valid && r1_valid) begin
      gnt_id = pref_id;
    end else if (r1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Ready is only offered in IDLE, only to the granted port, and is forced
  // low while reset is asserted.
  assign r0_ready = rst_n && (state == IDLE) && r0_valid && !gnt_id;
  assign r1_ready = rst_n && (state == IDLE) && r1_valid &&  gnt_id;
  assign hs       = r0_ready || r1_ready;

  assign sel_wr    = gnt_id ? r1_wr    : r0_wr;
  assign sel_addr  = gnt_id ? r1_addr  : r0_addr;
  assign sel_wdata = gnt_id ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pref_id   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= 1'b0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      config_we <= 1'b0;
      config_re <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            lat_wr    <= sel_wr;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_id    <= gnt_id;
            pref_id   <= ~gnt_id;
            // Strobes are registered here so they are high for exactly the
            // single ISSUE cycle.
            config_we <= sel_wr;
            config_re <= ~sel_wr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          config_we <= 1'b0;
          config_re <= 1'b0;
          if (lat_wr) begin
`ifdef CFG_WR_ACK_EN
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RSP;
`else
            state     <= IDLE;
`endif
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // config_rdata is valid in this cycle, one cycle after config_re.
          rsp_rdata <= config_rdata;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Address and data stay on the latched values through CAPTURE and RSP.
  assign config_waddr = lat_addr;
  assign config_raddr = lat_addr;
  assign config_wdata = lat_wdata;
  assign rsp_id       = lat_id;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_cfg_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cfg_port_arbiter
//
// Bench for cfg_port_arbiter. Drivers present requests on r0/r1; a
// transaction-level model (round-robin rule, flat memory) turns every accepted
// request into an expected strobe and, where applicable, an expected
// response. Independent monitors pop and compare those when the DUT strobes
// the config bus or presents a response. Directed sequences cover reset,
// latency, arbitration order, response stall and mid-transaction reset, then
// a randomized phase runs both ports concurrently.
// ---------------------------------------------------------------------------
module tb_cfg_port_arbiter;

  localparam int CAW = 15;
  localparam int CDW = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic           r0_valid, r0_ready, r0_wr;
  logic [CAW-1:0] r0_addr;
  logic [CDW-1:0] r0_wdata;
  logic           r1_valid, r1_ready, r1_wr;
  logic [CAW-1:0] r1_addr;
  logic [CDW-1:0] r1_wdata;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic [CDW-1:0] rsp_rdata;
  logic           config_we, config_re;
  logic [CAW-1:0] config_waddr, config_raddr;
  logic [CDW-1:0] config_wdata;
  logic [CDW-1:0] config_rdata;
  logic           busy;
  logic [1:0]     dbg_state;

  cfg_port_arbiter #(.CAW(CAW), .CDW(CDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_wr        (r0_wr),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_wr        (r1_wr),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_rdata    (rsp_rdata),
    .config_we    (config_we),
    .config_re    (config_re),
    .config_waddr (config_waddr),
    .config_raddr (config_raddr),
    .config_wdata (config_wdata),
    .config_rdata (config_rdata),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic           wr;
    logic [CAW-1:0] addr;
    logic [CDW-1:0] wdata;
  } req_t;

  typedef struct {
    logic           wr;
    logic [CAW-1:0] addr;
    logic [CDW-1:0] wdata;
    int             due;
  } stb_t;

  typedef struct {
    logic           id;
    logic [CDW-1:0] rdata;
    int             due;
  } rsp_t;

  req_t req0_q[$];
  req_t req1_q[$];
  stb_t stb_q[$];
  rsp_t exp_q[$];
  int   hs_port_log[$];
  int   hs_cyc_log[$];

  logic [CDW-1:0] ref_mem   [logic [CAW-1:0]];
  logic [CDW-1:0] slave_mem [logic [CAW-1:0]];
  logic           m_last = 1'b1;   // model: port granted last (reset: as if r1)
  int             rsp_count = 0;
  int             total = 0;
  int             bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- config register-file slave ----------------
  // Read data appears one cycle after config_re; other cycles carry junk so a
  // mistimed capture is visible.
  always @(posedge clk) begin
    if (config_re)
      config_rdata <= slave_mem.exists(config_raddr) ? slave_mem[config_raddr] : '0;
    else
      config_rdata <= CDW'($urandom);
    if (config_we)
      slave_mem[config_waddr] = config_wdata;
  end

  // ---------------- response-ready driver ----------------
  logic rand_rr = 1'b0;
  logic rr_hold = 1'b1;
  always @(posedge clk) begin
    #1;
    rsp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : rr_hold;
  end

  // ---------------- request driver ----------------
  task automatic send(input int p, input logic wr, input logic [CAW-1:0] addr,
                      input logic [CDW-1:0] wdata);
    req_t r;
    int   n;
    bit   got;
    r.wr = wr; r.addr = addr; r.wdata = wdata;
    if (p == 0) begin
      req0_q.push_back(r);
      r0_wr = wr; r0_addr = addr; r0_wdata = wdata; r0_valid = 1'b1;
    end else begin
      req1_q.push_back(r);
      r1_wr = wr; r1_addr = addr; r1_wdata = wdata; r1_valid = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      if ((p == 0) ? r0_ready : r1_ready) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL r%0d_handshake_timeout: no ready after %0d cycles, want ready", p, n);
      if (p == 0) void'(req0_q.pop_back()); else void'(req1_q.pop_back());
    end
    @(posedge clk); #1;
    if (p == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  // ---------------- model: handshake -> expectations ----------------
  logic hs_p, hs_exp_p;
  req_t hs_r;
  stb_t hs_s;
  rsp_t hs_e;
  bit   hs_ok;

  always @(negedge clk) begin
    if (!rst_n) begin
      stb_q.delete();
      exp_q.delete();
      m_last = 1'b1;
    end else if (r0_ready || r1_ready) begin
      hs_p     = r1_ready;
      hs_exp_p = (r0_valid && r1_valid) ? ~m_last : r1_valid;
      chk("single_ready", 32'(r0_ready & r1_ready), 0);
      chk("grant_port", 32'(hs_p), 32'(hs_exp_p));
      m_last = hs_p;
      hs_ok = hs_p ? (req1_q.size() != 0) : (req0_q.size() != 0);
      if (!hs_ok) begin
        total++; bad++;
        $display("FAIL phantom_handshake: port %0d accepted with no request pending", hs_p);
      end else begin
        hs_r = hs_p ? req1_q.pop_front() : req0_q.pop_front();
        hs_s.wr = hs_r.wr; hs_s.addr = hs_r.addr; hs_s.wdata = hs_r.wdata; hs_s.due = cyc + 1;
        stb_q.push_back(hs_s);
        hs_e.id = hs_p;
        if (hs_r.wr) begin
          ref_mem[hs_r.addr] = hs_r.wdata;
`ifdef CFG_WR_ACK_EN
          hs_e.rdata = '0;
          hs_e.due   = cyc + 2;
          exp_q.push_back(hs_e);
`endif
        end else begin
          hs_e.rdata = ref_mem.exists(hs_r.addr) ? ref_mem[hs_r.addr] : '0;
          hs_e.due   = cyc + 3;
          exp_q.push_back(hs_e);
        end
        hs_port_log.push_back(int'(hs_p));
        hs_cyc_log.push_back(cyc);
      end
    end
  end

  // ---------------- monitor: config strobes ----------------
  stb_t           sb;
  logic           cap_chk = 1'b0;
  logic [CAW-1:0] cap_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_chk = 1'b0;
    end else begin
      if (cap_chk) begin
        chk("raddr_hold_capture", 32'(config_raddr), 32'(cap_addr));
        cap_chk = 1'b0;
      end
      if (config_we || config_re) begin
        chk("we_re_exclusive", 32'(config_we & config_re), 0);
        if (stb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: we=%0d re=%0d addr=0x%0h, want no strobe",
                   config_we, config_re, config_waddr);
        end else begin
          sb = stb_q.pop_front();
          chk("strobe_is_write", 32'(config_we), 32'(sb.wr));
          chk("strobe_cycle", cyc, sb.due);
          chk("waddr", 32'(config_waddr), 32'(sb.addr));
          chk("raddr", 32'(config_raddr), 32'(sb.addr));
          if (sb.wr) chk("wdata", 32'(config_wdata), 32'(sb.wdata));
          else begin cap_chk = 1'b1; cap_addr = sb.addr; end
        end
      end
    end
  end

  // ---------------- monitor: responses ----------------
  logic           pv = 1'b0, pr = 1'b0, pid = 1'b0;
  logic [CDW-1:0] pdata = '0;
  rsp_t           re;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 1);
        chk("rsp_hold_id", 32'(rsp_id), 32'(pid));
        chk("rsp_hold_data", 32'(rsp_rdata), 32'(pdata));
      end
      if (rsp_valid && !pv && exp_q.size() != 0)
        chk("rsp_cycle", cyc, exp_q[0].due);
      if (rsp_valid && (r0_valid || r1_valid))
        chk("ready_blocked_in_rsp", 32'(r0_ready | r1_ready), 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: id=%0d data=0x%0h, want no response", rsp_id, rsp_rdata);
        end else begin
          re = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(re.id));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(re.rdata));
        end
        rsp_count++;
      end
      pv = rsp_valid; pr = rsp_ready; pid = rsp_id; pdata = rsp_rdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || stb_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL drain_%s: pending rsp=%0d strobe=%0d busy=%0d, want all 0",
               tag, exp_q.size(), stb_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base;
  int n_wait;
  int c0;

  initial begin
    r0_valid = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;
    rst_n = 1'b0;
    r0_valid = 1'b1;   // ready must stay low while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_r0_ready", 32'(r0_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_state", 32'(dbg_state), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_we", 32'(config_we), 0);
    chk("reset_re", 32'(config_re), 0);
    chk("reset_rdata", 32'(rsp_rdata), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_addr", 32'(config_waddr), 0);
    r0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin from reset: both ports hold valid for two writes each.
    base = hs_port_log.size();
    fork
      begin send(0, 1'b1, 15'h0010, 21'h00011); send(0, 1'b1, 15'h0011, 21'h00012); end
      begin send(1, 1'b1, 15'h0020, 21'h00021); send(1, 1'b1, 15'h0021, 21'h00022); end
    join
    if (hs_port_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("arb_order_%0d", i), hs_port_log[base + i], i % 2);
    end else begin
      total++; bad++;
      $display("FAIL arb_order: %0d grants seen, want 4", hs_port_log.size() - base);
    end
    drain("arb");

    // Single write on r0.
    send(0, 1'b1, 15'h0001, 21'h00040);
`ifdef CFG_WR_ACK_EN
    @(negedge clk);              // N+1
    @(negedge clk);              // N+2
    chk("wr_ack_valid", 32'(rsp_valid), 1);
    chk("wr_ack_id", 32'(rsp_id), 0);
    chk("wr_ack_rdata", 32'(rsp_rdata), 0);
`else
    repeat (4) begin
      @(negedge clk);
      chk("write_no_rsp", 32'(rsp_valid), 0);
    end
`endif
    drain("wr");

    // Preload 0x2003 through r0, then read it back on r1.
    send(0, 1'b1, 15'h2003, 21'h0ABCD);
    drain("preload");
    send(1, 1'b0, 15'h2003, '0);
    @(negedge clk);              // N+1
    @(negedge clk);              // N+2
    chk("rd_not_early", 32'(rsp_valid), 0);
    @(negedge clk);              // N+3
    chk("rd_valid_n3", 32'(rsp_valid), 1);
    chk("rd_id", 32'(rsp_id), 1);
    chk("rd_data", 32'(rsp_rdata), 32'h0ABCD);
    drain("rd");

    // Back-to-back reads: next handshake four cycles after the previous one.
    send(1, 1'b0, 15'h2003, '0);
    send(1, 1'b0, 15'h0001, '0);
    chk("rd_rd_spacing", hs_cyc_log[hs_cyc_log.size()-1] - hs_cyc_log[hs_cyc_log.size()-2], 4);
    drain("rdrd");

    // Back-to-back writes.
    send(0, 1'b1, 15'h0005, 21'h00055);
    send(0, 1'b1, 15'h0006, 21'h00066);
`ifdef CFG_WR_ACK_EN
    chk("wr_wr_spacing", hs_cyc_log[hs_cyc_log.size()-1] - hs_cyc_log[hs_cyc_log.size()-2], 3);
`else
    chk("wr_wr_spacing", hs_cyc_log[hs_cyc_log.size()-1] - hs_cyc_log[hs_cyc_log.size()-2], 2);
`endif
    drain("wrwr");

    // Response stall: read on r1 while r0 is waiting with a write.
    rr_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(1, 1'b0, 15'h2003, '0);
    fork
      send(0, 1'b1, 15'h0030, 21'h00033);
    join_none
    n_wait = 0;
    while (!rsp_valid && n_wait < 20) begin @(negedge clk); n_wait++; end
    c0 = rsp_count;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", 32'(rsp_rdata), 32'h0ABCD);
      chk("stall_r0_ready", 32'(r0_ready), 0);
      chk("stall_r1_ready", 32'(r1_ready), 0);
    end
    rr_hold = 1'b1;
    n_wait = 0;
    while (rsp_count == c0 && n_wait < 20) begin @(negedge clk); n_wait++; end
    @(negedge clk);
    chk("stall_single_rsp", rsp_count - c0, 1);
    wait fork;
    drain("stall");

    // Reset during the ISSUE cycle of a read.
    send(1, 1'b0, 15'h0001, '0);   // returns inside ISSUE
    rst_n = 1'b0;
    #1;
    chk("midrst_re_drop", 32'(config_re), 0);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_state", 32'(dbg_state), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("postrst_no_re", 32'(config_re), 0);
      chk("postrst_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;

    // Randomized traffic on both ports with random response back-pressure.
    rand_rr = 1'b1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(0, 1'($urandom_range(0, 1)), CAW'($urandom_range(0, 7)), CDW'($urandom));
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(1, 1'($urandom_range(0, 1)), CAW'($urandom_range(0, 7)), CDW'($urandom));
      end
    join
    drain("random");
    rand_rr = 1'b0;
    repeat (2) @(posedge clk);
    chk("final_rsp_queue", exp_q.size(), 0);
    chk("final_strobe_queue", stb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
